cordic_nco_ctrl: RTL and testbench
==================================

Name: cordic_nco_ctrl

Overview:
Phase-accumulator NCO front end that sits directly upstream of cordic_sincos. It generates the 32-bit phase word (full circle = 2^32), issues one start pulse per sample period, and waits for the rotator's data_valid. It then captures sine/cosine into a ready/valid output register for downstream DSP. It also flags lost sample ticks (overrun) and CORDIC non-response (timeout).

Parameters:
PHASE_W, 32, phase word width; 2^PHASE_W = 2π rad
DATA_W, 16, signed sine/cosine width
PER_W, 16, width of the sample-period counter
TIMEOUT, 64, max cycles from start_out to data_valid before abort

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
enable  in  1  run; low = stop launching new samples
cfg_load  in  1  one-cycle strobe; latch ftw_in, phase_ofs_in, period_in
phase_clr  in  1  one-cycle strobe; zero the phase accumulator
ftw_in  in  PHASE_W  frequency tuning word (phase increment per sample)
phase_ofs_in  in  PHASE_W  phase offset added to accumulator
period_in  in  PER_W  clk cycles per sample tick; 0 treated as 1
angle_out  out  PHASE_W  to cordic_sincos angle_in
start_out  out  1  to cordic_sincos start; one-cycle pulse
cordic_valid_in  in  1  from cordic_sincos data_valid
cordic_sin_in  in  DATA_W  from cordic_sincos sine_out (signed)
cordic_cos_in  in  DATA_W  from cordic_sincos cosine_out (signed)
sample_sin  out  DATA_W  captured sine
sample_cos  out  DATA_W  captured cosine
sample_valid  out  1  output sample available
sample_ready  in  1  downstream accepts sample
busy  out  1  FSM not in IDLE
overrun  out  1  sticky; a tick was dropped
timeout_err  out  1  sticky; CORDIC did not respond within TIMEOUT

Behaviour:
- Reset (rst=1 at posedge): all outputs 0. Accumulator, config registers, tick counter and timeout counter are 0. FSM goes to IDLE. This applies mid-transaction too; any in-flight CORDIC result is ignored.
- Config: on cfg_load, ftw/ofs/period latch the next cycle. The new values apply from the next tick. The accumulator is not altered. cfg_load is legal in any state.
- phase_clr: the accumulator is 0 on the next cycle. If phase_clr coincides with a tick, the clear wins and that tick launches angle = ofs.
- Tick counter: runs only while enable=1. It counts 0..max(period,1)-1 and a tick fires at wrap. It holds its value when enable=0.
- FSM states:
  - IDLE: go to WAIT_TICK when enable=1.
  - WAIT_TICK: on a tick, register angle_out = acc + ofs (mod 2^32), then acc <= acc + ftw (mod 2^32, wraps silently), then go to LAUNCH. If enable=0, return to IDLE.
  - LAUNCH: start_out=1 for exactly this cycle. Clear the timeout counter. Go to WAIT_RESULT.
  - WAIT_RESULT: increment the timeout counter each cycle.
    - On cordic_valid_in=1, go to PUSH. This is level-sensitive; the first high cycle is used. A valid asserted during the LAUNCH cycle is ignored.
    - If the counter reaches TIMEOUT with no valid, set timeout_err and go to WAIT_TICK. No sample is produced.
  - PUSH: if sample_valid=0, or sample_ready=1 in this cycle, load sample_sin/cos and set sample_valid=1, then go to WAIT_TICK (or IDLE if enable=0). Otherwise stay in PUSH, re-capture the CORDIC outputs each cycle, and keep the previous sample held.
- Output handshake: sample_valid clears on sample_valid & sample_ready unless a new load occurs in the same cycle. Data is stable while valid=1 and ready=0.
- angle_out holds its value between launches. start_out is never asserted outside LAUNCH.
- Overrun: a tick that arrives in any state other than WAIT_TICK sets overrun. The accumulator still advances by ftw, keeping phase continuous; the sample is skipped.
- overrun and timeout_err clear only on rst or cfg_load.
- enable dropping mid-transaction: the current transaction completes through PUSH, then the FSM goes to IDLE.
- Latency: tick to start_out = 2 cycles. data_valid to sample_valid = 1 cycle when the output is free.

Decomposition:
- Shared package cordic_pkg:
  - PHASE_W, DATA_W
  - phase constants PH_0=0x00000000, PH_90=0x40000000, PH_180=0x80000000, PH_270=0xC0000000
  - FSM state enum
- One natural sub-module: nco_phase_acc (accumulator, offset add, phase_clr/tick arbitration, wrap).
- FSM and output register stay in the top module.

Test Plan:
- Basic sequencing: ftw=0x20000000, ofs=0, period=40, CORDIC model with 20-cycle latency. Required: angle_out sequence 0x0, 0x20000000, …, 0xE0000000, then wraps to 0x0. Exactly one start_out per tick. No overrun.
- Offset: ofs=0x40000000, ftw=0. Required: every launch has angle_out=0x40000000. With model sin=32767, cos=0, sample_sin=32767 and sample_cos=0 on each sample.
- Overrun: period=5, latency 20. Required: overrun=1 after the second tick. Launched angles step by a multiple of ftw, with no phase slip.
- Timeout: cordic_valid_in tied 0. Required: timeout_err=1 exactly TIMEOUT cycles after start_out. The FSM returns to WAIT_TICK and sample_valid stays 0.
- Backpressure: sample_ready=0 for 100 cycles. Required: the first sample is held stable with sample_valid=1 and the FSM stalls in PUSH. After ready=1, samples are delivered in order and none are duplicated.
- Reset mid-op: assert rst while in WAIT_RESULT. Required: all outputs 0 the next cycle. A late cordic_valid_in produces no sample.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared definitions for the NCO front end and the CORDIC rotator it feeds.
package cordic_pkg;

  localparam int PHASE_W = 32;
  localparam int DATA_W  = 16;

  localparam logic [31:0] PH_0   = 32'h0000_0000;
  localparam logic [31:0] PH_90  = 32'h4000_0000;
  localparam logic [31:0] PH_180 = 32'h8000_0000;
  localparam logic [31:0] PH_270 = 32'hC000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_LAUNCH,
    ST_WAIT_RESULT,
    ST_PUSH
  } nco_state_e;

endpackage

// File: rtl/nco_phase_acc.sv
// Phase accumulator: advances by ftw on every sample tick, zeroed by phase_clr.
module nco_phase_acc #(
  parameter int PHASE_W = cordic_pkg::PHASE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               phase_clr,
  input  logic [PHASE_W-1:0] ftw,
  input  logic [PHASE_W-1:0] ofs,
  output logic [PHASE_W-1:0] launch_angle
);
  import cordic_pkg::*;

  logic [PHASE_W-1:0] acc;

  // A clear coinciding with a tick wins; that tick launches from zero phase.
  always_ff @(posedge clk) begin
    if (rst)            acc <= PHASE_W'(PH_0);
    else if (phase_clr) acc <= PHASE_W'(PH_0);
    else if (tick)      acc <= acc + ftw;
  end

  assign launch_angle = (phase_clr ? PHASE_W'(PH_0) : acc) + ofs;

endmodule

// File: rtl/cordic_nco_ctrl.sv
// NCO sequencer: ticks a phase accumulator, launches the CORDIC, and registers
// each sine/cosine result into a ready/valid output stage.
//
// state          | meaning
// ST_IDLE        | stopped, waiting for enable
// ST_WAIT_TICK   | armed, next sample tick launches a rotation
// ST_LAUNCH      | start_out high this cycle, timeout timer loaded
// ST_WAIT_RESULT | waiting for data_valid from the rotator
// ST_PUSH        | result held, output register still occupied
module cordic_nco_ctrl #(
  parameter int PHASE_W = cordic_pkg::PHASE_W,
  parameter int DATA_W  = cordic_pkg::DATA_W,
  parameter int PER_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               cfg_load,
  input  logic               phase_clr,
  input  logic [PHASE_W-1:0] ftw_in,
  input  logic [PHASE_W-1:0] phase_ofs_in,
  input  logic [PER_W-1:0]   period_in,
  output logic [PHASE_W-1:0] angle_out,
  output logic               start_out,
  input  logic               cordic_valid_in,
  input  logic [DATA_W-1:0]  cordic_sin_in,
  input  logic [DATA_W-1:0]  cordic_cos_in,
  output logic [DATA_W-1:0]  sample_sin,
  output logic [DATA_W-1:0]  sample_cos,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic               busy,
  output logic               overrun,
  output logic               timeout_err
);
  import cordic_pkg::*;

  localparam int TMR_W = $clog2(TIMEOUT) + 1;

  logic [PHASE_W-1:0] ftw_q;
  logic [PHASE_W-1:0] ofs_q;
  logic [PER_W-1:0]   period_q;
  logic [PER_W-1:0]   per_last;
  logic [PER_W-1:0]   tick_cnt;
  logic               tick_q;
  logic               tick;
  logic [PHASE_W-1:0] launch_angle;
  logic [TMR_W-1:0]   tmr;
  logic               out_free;
  nco_state_e         state;

  always_ff @(posedge clk) begin
    if (rst) begin
      ftw_q    <= '0;
      ofs_q    <= '0;
      period_q <= '0;
    end else if (cfg_load) begin
      ftw_q    <= ftw_in;
      ofs_q    <= phase_ofs_in;
      period_q <= period_in;
    end
  end

  // >= keeps the counter bounded when the period is shortened mid-count.
  assign per_last = (period_q == '0) ? '0 : period_q - PER_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      tick_q   <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (enable) begin
        if (tick_cnt >= per_last) begin
          tick_cnt <= '0;
          tick_q   <= 1'b1;
        end else begin
          tick_cnt <= tick_cnt + PER_W'(1);
        end
      end
    end
  end

  assign tick = tick_q & enable;

  nco_phase_acc #(.PHASE_W(PHASE_W)) u_phase_acc (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .phase_clr    (phase_clr),
    .ftw          (ftw_q),
    .ofs          (ofs_q),
    .launch_angle (launch_angle)
  );

  assign out_free = !sample_valid || sample_ready;
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      angle_out    <= '0;
      start_out    <= 1'b0;
      tmr          <= '0;
      sample_sin   <= '0;
      sample_cos   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      start_out <= 1'b0;
      if (sample_valid && sample_ready) sample_valid <= 1'b0;
      if (cfg_load) begin
        overrun     <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (tick && state != ST_WAIT_TICK) overrun <= 1'b1;

      case (state)
        ST_IDLE: if (enable) state <= ST_WAIT_TICK;
        ST_WAIT_TICK: begin
          if (tick) begin
            angle_out <= launch_angle;
            start_out <= 1'b1;
            state     <= ST_LAUNCH;
          end else if (!enable) begin
            state <= ST_IDLE;
          end
        end
        ST_LAUNCH: begin
          tmr   <= TMR_W'(TIMEOUT - 2);
          state <= ST_WAIT_RESULT;
        end
        ST_WAIT_RESULT: begin
          // A free output register takes the result straight away (1-cycle latency).
          if (cordic_valid_in) begin
            if (out_free) begin
              sample_sin   <= cordic_sin_in;
              sample_cos   <= cordic_cos_in;
              sample_valid <= 1'b1;
              state        <= enable ? ST_WAIT_TICK : ST_IDLE;
            end else begin
              state <= ST_PUSH;
            end
          end else if (tmr == '0) begin
            timeout_err <= 1'b1;
            state       <= ST_WAIT_TICK;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        ST_PUSH: begin
          if (out_free) begin
            sample_sin   <= cordic_sin_in;
            sample_cos   <= cordic_cos_in;
            sample_valid <= 1'b1;
            state        <= enable ? ST_WAIT_TICK : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_nco_ctrl.sv
// Bench for cordic_nco_ctrl: behavioural CORDIC responder plus sample scoreboard.
module tb_cordic_nco_ctrl;
  import cordic_pkg::*;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        cfg_load = 1'b0;
  logic        phase_clr = 1'b0;
  logic [31:0] ftw_in = '0;
  logic [31:0] phase_ofs_in = '0;
  logic [15:0] period_in = '0;
  logic [31:0] angle_out;
  logic        start_out;
  logic        cordic_valid_in = 1'b0;
  logic [15:0] cordic_sin_in = '0;
  logic [15:0] cordic_cos_in = '0;
  logic [15:0] sample_sin;
  logic [15:0] sample_cos;
  logic        sample_valid;
  logic        sample_ready = 1'b1;
  logic        busy;
  logic        overrun;
  logic        timeout_err;

  cordic_nco_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_load(cfg_load), .phase_clr(phase_clr),
    .ftw_in(ftw_in), .phase_ofs_in(phase_ofs_in), .period_in(period_in),
    .angle_out(angle_out), .start_out(start_out), .cordic_valid_in(cordic_valid_in),
    .cordic_sin_in(cordic_sin_in), .cordic_cos_in(cordic_cos_in),
    .sample_sin(sample_sin), .sample_cos(sample_cos), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // CORDIC responder settings and scoreboard
  int          lat = 20;
  bit          respond = 1'b1;
  bit          fixed_mode = 1'b0;
  bit          push_en = 1'b1;
  bit          pend = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_ang = '0;
  int          valid_cyc = 0;
  logic [31:0] sb_q[$];

  always @(negedge clk) begin
    cordic_valid_in = 1'b0;
    if (start_out) begin
      pend  = respond;
      m_cnt = lat;
      m_ang = angle_out;
    end else if (pend) begin
      m_cnt--;
      if (m_cnt == 0) begin
        pend = 1'b0;
        cordic_valid_in = 1'b1;
        if (fixed_mode) begin
          cordic_sin_in = 16'h7FFF;
          cordic_cos_in = 16'h0000;
        end else begin
          cordic_sin_in = m_ang[31:16];
          cordic_cos_in = ~m_ang[31:16];
        end
        valid_cyc = cyc;
        if (push_en) sb_q.push_back({cordic_sin_in, cordic_cos_in});
      end
    end
  end

  // Monitor: launch angles, tick spacing, result latency, delivered samples
  int          ang_mode = 0;
  logic [31:0] ang_base = '0;
  logic [31:0] ang_step = '0;
  int          start_base = 0;
  int          spacing_exp = 0;
  bit          lat_chk = 1'b0;
  int          n_start = 0;
  int          n_pop = 0;
  int          last_start_cyc = 0;
  logic [31:0] prev_ang = '0;
  logic        prev_sv = 1'b0;

  always @(negedge clk) begin
    logic [31:0] exp_ang;
    logic [31:0] d;
    if (!rst) begin
      if (start_out) begin
        if (ang_mode == 1) begin
          exp_ang = ang_base + ang_step * 32'(n_start - start_base);
          expect_eq("angle", angle_out, exp_ang);
        end else if (ang_mode == 2 && n_start > start_base) begin
          d = angle_out - prev_ang;
          expect_eq("phase_step_multiple", d & (ang_step - 32'd1), 0);
          expect_eq("phase_advanced", d == 32'd0, 0);
        end
        if (spacing_exp > 0 && n_start > start_base)
          expect_eq("tick_spacing", cyc - last_start_cyc, spacing_exp);
        prev_ang = angle_out;
        last_start_cyc = cyc;
        n_start++;
      end
      if (lat_chk && sample_valid && !prev_sv)
        expect_eq("valid_latency", cyc - valid_cyc, 1);
      if (sample_valid && sample_ready) begin
        expect_eq("sb_nonempty", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          expect_eq("sample", {sample_sin, sample_cos}, sb_q.pop_front());
          n_pop++;
        end
      end
    end
    prev_sv = sample_valid;
  end

  task automatic step_in();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [31:0] f, input logic [31:0] o, input logic [15:0] p);
    step_in();
    ftw_in = f; phase_ofs_in = o; period_in = p; cfg_load = 1'b1;
    step_in();
    cfg_load = 1'b0;
  endtask

  task automatic clr_phase();
    step_in();
    phase_clr = 1'b1;
    step_in();
    phase_clr = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int budget, input string tag);
    int k = 0;
    while (n_start < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    expect_eq(tag, n_start, n);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    expect_eq(tag, busy, 0);
  endtask

  task automatic wait_start_pulse(input int budget, input string tag);
    int k = 0;
    while (!start_out && k < budget) begin
      @(negedge clk);
      k++;
    end
    expect_eq(tag, start_out, 1);
  endtask

  initial begin
    int k;
    int pop_base;
    bit sv_seen;

    repeat (3) @(posedge clk);
    @(negedge clk);
    expect_eq("rst_angle", angle_out, 0);
    expect_eq("rst_flags", {start_out, sample_valid, busy, overrun, timeout_err}, 0);
    expect_eq("rst_sample", {sample_sin, sample_cos}, 0);
    step_in();
    rst = 1'b0;

    // Basic sequencing: eight phase steps then wrap to zero
    cfg(32'h2000_0000, PH_0, 16'd40);
    lat = 20;
    start_base = n_start; ang_mode = 1; ang_base = PH_0; ang_step = 32'h2000_0000;
    spacing_exp = 40; lat_chk = 1'b1;
    step_in();
    enable = 1'b1;
    wait_starts(start_base + 9, 9 * 40 + 200, "basic_starts");
    step_in();
    enable = 1'b0;
    wait_idle(200, "basic_idle");
    expect_eq("basic_start_count", n_start - start_base, 9);
    expect_eq("basic_no_overrun", overrun, 0);
    expect_eq("basic_sb_drained", sb_q.size(), 0);

    // Constant offset, zero tuning word
    cfg(32'h0, PH_90, 16'd40);
    clr_phase();
    lat = 5; fixed_mode = 1'b1;
    start_base = n_start; ang_mode = 1; ang_base = PH_90; ang_step = 32'h0;
    step_in();
    enable = 1'b1;
    wait_starts(start_base + 3, 3 * 40 + 200, "ofs_starts");
    step_in();
    enable = 1'b0;
    wait_idle(200, "ofs_idle");
    expect_eq("ofs_sin", sample_sin, 16'h7FFF);
    expect_eq("ofs_cos", sample_cos, 16'h0000);
    fixed_mode = 1'b0; lat_chk = 1'b0; spacing_exp = 0;

    // Overrun: period shorter than the CORDIC latency
    clr_phase();
    cfg(32'h0100_0000, PH_0, 16'd5);
    lat = 20;
    start_base = n_start; ang_mode = 2; ang_step = 32'h0100_0000;
    step_in();
    enable = 1'b1;
    k = 0;
    while (!overrun && k < 100) begin
      @(negedge clk);
      k++;
    end
    expect_eq("ovr_set", overrun, 1);
    expect_eq("ovr_after_first_launch", n_start - start_base, 1);
    wait_starts(start_base + 4, 300, "ovr_starts");
    step_in();
    enable = 1'b0;
    wait_idle(200, "ovr_idle");
    expect_eq("ovr_sticky", overrun, 1);
    cfg(32'h0100_0000, PH_0, 16'd5);
    @(negedge clk);
    expect_eq("ovr_cleared_by_cfg", overrun, 0);
    ang_mode = 0;

    // Timeout: CORDIC never answers
    respond = 1'b0;
    cfg(32'h0100_0000, PH_0, 16'd200);
    step_in();
    enable = 1'b1;
    wait_start_pulse(400, "to_start");
    k = 0;
    while (!timeout_err && k < 200) begin
      @(negedge clk);
      k++;
    end
    expect_eq("timeout_cycles", k, TIMEOUT);
    expect_eq("timeout_back_to_wait", busy, 1);
    expect_eq("timeout_no_sample", sample_valid, 0);
    step_in();
    enable = 1'b0;
    wait_idle(100, "to_idle");
    expect_eq("timeout_sticky", timeout_err, 1);
    expect_eq("timeout_no_sample_end", sample_valid, 0);
    respond = 1'b1;
    cfg(32'h0100_0000, PH_0, 16'd200);
    @(negedge clk);
    expect_eq("timeout_cleared_by_cfg", timeout_err, 0);

    // Backpressure: output held for 100 cycles, then drained in order
    clr_phase();
    cfg(32'h1000_0000, PH_0, 16'd30);
    lat = 5;
    start_base = n_start; ang_mode = 1; ang_base = PH_0; ang_step = 32'h1000_0000;
    pop_base = n_pop;
    step_in();
    sample_ready = 1'b0;
    enable = 1'b1;
    repeat (50) @(negedge clk);
    expect_eq("bp_hold_mid", {sample_sin, sample_cos}, sb_q[0]);
    repeat (50) @(negedge clk);
    expect_eq("bp_valid", sample_valid, 1);
    expect_eq("bp_hold_end", {sample_sin, sample_cos}, sb_q[0]);
    expect_eq("bp_stalled_starts", n_start - start_base, 2);
    expect_eq("bp_busy", busy, 1);
    step_in();
    enable = 1'b0;
    sample_ready = 1'b1;
    wait_idle(100, "bp_idle");
    expect_eq("bp_delivered", n_pop - pop_base, 2);
    expect_eq("bp_sb_drained", sb_q.size(), 0);
    ang_mode = 0;

    // Reset while waiting for the CORDIC; its late result must be dropped
    cfg(32'h1000_0000, PH_0, 16'd20);
    lat = 30;
    step_in();
    enable = 1'b1;
    wait_start_pulse(100, "rst_mid_start");
    repeat (5) @(negedge clk);
    push_en = 1'b0;
    step_in();
    rst = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    expect_eq("rstmid_angle", angle_out, 0);
    expect_eq("rstmid_flags", {start_out, sample_valid, busy, overrun, timeout_err}, 0);
    expect_eq("rstmid_sample", {sample_sin, sample_cos}, 0);
    sv_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      sv_seen |= sample_valid;
    end
    expect_eq("rstmid_no_late_sample", sv_seen, 0);
    expect_eq("rstmid_idle", busy, 0);
    push_en = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
